// File: rtl/matmul_sequencer.sv
// Sequencer for the 2x2 signed 8-bit matrix multiplier: streams A/B bytes into
// its memories, waits for the product, streams C out, then clears the multiplier.
module matmul_sequencer #(
   parameter int SETTLE_CYC = 2,
   parameter int RD_LAT     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        abort,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [16:0] m_data,
   output logic [1:0]  m_idx,
   output logic        m_last,
   output logic        busy,
   output logic        done,
   output logic        mm_data_in,
   output logic        mm_mem_sel,
   output logic        mm_row_in,
   output logic        mm_col_in,
   output logic [7:0]  mm_data,
   output logic        mm_row_out,
   output logic        mm_col_out,
   input  logic [16:0] mm_out,
   output logic        mm_reset,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      LOAD   = 3'd0,
      SETTLE = 3'd1,
      READ   = 3'd2,
      SEND   = 3'd3,
      CLEAR  = 3'd4
   } state_t;

   // wait_cnt serves both the settle delay and the read latency.
   localparam int WMAX = (SETTLE_CYC > RD_LAT) ? SETTLE_CYC : RD_LAT;
   localparam int WW   = (WMAX < 2) ? 1 : $clog2(WMAX);
   localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE_CYC - 1);
   localparam logic [WW-1:0] RD_LAST     = WW'(RD_LAT - 1);

   state_t          state;
   logic [2:0]      ld_cnt;
   logic [WW-1:0]   wait_cnt;
   logic [1:0]      rd_cnt;
   logic [1:0]      rd_next;
   logic            s_fire;
   logic            m_fire;

   // Both streams transfer a beat on a rising edge where valid and ready are
   // both high and abort is low; a producer holds valid and its payload
   // unchanged until that edge, and ready never depends combinationally on valid.
   assign s_fire    = s_valid & s_ready & ~abort;
   assign m_fire    = m_valid & m_ready & ~abort;
   assign rd_next   = rd_cnt + 2'd1;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= LOAD;
         ld_cnt     <= 3'd0;
         wait_cnt   <= '0;
         rd_cnt     <= 2'd0;
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= 17'd0;
         m_idx      <= 2'd0;
         m_last     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mm_data_in <= 1'b0;
         mm_mem_sel <= 1'b0;
         mm_row_in  <= 1'b0;
         mm_col_in  <= 1'b0;
         mm_data    <= 8'd0;
         mm_row_out <= 1'b0;
         mm_col_out <= 1'b0;
         mm_reset   <= 1'b0;
      end else begin
         mm_data_in <= 1'b0;
         done       <= 1'b0;
         mm_reset   <= 1'b0;
         if (abort && state != CLEAR) begin
            // Cancel: clear the multiplier without reporting completion.
            state    <= CLEAR;
            mm_reset <= 1'b1;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            busy     <= 1'b1;
            ld_cnt   <= 3'd0;
            wait_cnt <= '0;
            rd_cnt   <= 2'd0;
         end else begin
            case (state)
               LOAD: begin
                  s_ready <= 1'b1;
                  if (s_fire) begin
                     mm_data_in <= 1'b1;
                     mm_mem_sel <= ld_cnt[2];
                     mm_row_in  <= ld_cnt[1];
                     mm_col_in  <= ld_cnt[0];
                     mm_data    <= s_data;
                     busy       <= 1'b1;
                     if (ld_cnt == 3'd7) begin
                        state    <= SETTLE;
                        ld_cnt   <= 3'd0;
                        wait_cnt <= '0;
                        s_ready  <= 1'b0;
                     end else begin
                        ld_cnt <= ld_cnt + 3'd1;
                     end
                  end
               end
               SETTLE: begin
                  // First settle cycle is the one carrying the last write strobe.
                  if (wait_cnt == SETTLE_LAST) begin
                     state      <= READ;
                     wait_cnt   <= '0;
                     rd_cnt     <= 2'd0;
                     mm_row_out <= 1'b0;
                     mm_col_out <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + WW'(1);
                  end
               end
               READ: begin
                  if (wait_cnt == RD_LAST) begin
                     m_data   <= mm_out;
                     m_idx    <= rd_cnt;
                     m_last   <= (rd_cnt == 2'd3);
                     m_valid  <= 1'b1;
                     wait_cnt <= '0;
                     state    <= SEND;
                  end else begin
                     wait_cnt <= wait_cnt + WW'(1);
                  end
               end
               SEND: begin
                  if (m_fire) begin
                     m_valid <= 1'b0;
                     if (rd_cnt == 2'd3) begin
                        state    <= CLEAR;
                        rd_cnt   <= 2'd0;
                        mm_reset <= 1'b1;
                        done     <= 1'b1;
                     end else begin
                        rd_cnt     <= rd_next;
                        mm_row_out <= rd_next[1];
                        mm_col_out <= rd_next[0];
                        state      <= READ;
                     end
                  end
               end
               CLEAR: begin
                  state    <= LOAD;
                  s_ready  <= 1'b1;
                  busy     <= 1'b0;
                  ld_cnt   <= 3'd0;
                  wait_cnt <= '0;
                  rd_cnt   <= 2'd0;
               end
               default: begin
                  state   <= LOAD;
                  s_ready <= 1'b0;
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a default instance with a behavioural multiplier,
// plus a second instance with longer settle/read latency.
module tb_matmul_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        abort;
   logic        s_valid, s_ready;
   logic [7:0]  s_data;
   logic        m_valid, m_ready;
   logic [16:0] m_data;
   logic [1:0]  m_idx;
   logic        m_last, busy, done;
   logic        mm_data_in, mm_mem_sel, mm_row_in, mm_col_in;
   logic [7:0]  mm_data;
   logic        mm_row_out, mm_col_out;
   logic [16:0] mm_out;
   logic        mm_reset;
   logic [2:0]  dbg_state;

   logic        abort2, s_valid2, s_ready2;
   logic [7:0]  s_data2;
   logic        m_valid2, m_ready2;
   logic [16:0] m_data2;
   logic [1:0]  m_idx2;
   logic        m_last2, busy2, done2;
   logic        mm_data_in2, mm_mem_sel2, mm_row_in2, mm_col_in2;
   logic [7:0]  mm_data2;
   logic        mm_row_out2, mm_col_out2;
   logic [16:0] mm_out2;
   logic        mm_reset2;
   logic [2:0]  dbg_state2;

   always #5 clk = ~clk;

   matmul_sequencer u_dut (
      .clk(clk), .reset(reset), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
      .busy(busy), .done(done),
      .mm_data_in(mm_data_in), .mm_mem_sel(mm_mem_sel), .mm_row_in(mm_row_in), .mm_col_in(mm_col_in),
      .mm_data(mm_data), .mm_row_out(mm_row_out), .mm_col_out(mm_col_out), .mm_out(mm_out),
      .mm_reset(mm_reset), .dbg_state(dbg_state)
   );

   matmul_sequencer #(.SETTLE_CYC(4), .RD_LAT(3)) u_sweep (
      .clk(clk), .reset(reset), .abort(abort2),
      .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
      .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_idx(m_idx2), .m_last(m_last2),
      .busy(busy2), .done(done2),
      .mm_data_in(mm_data_in2), .mm_mem_sel(mm_mem_sel2), .mm_row_in(mm_row_in2), .mm_col_in(mm_col_in2),
      .mm_data(mm_data2), .mm_row_out(mm_row_out2), .mm_col_out(mm_col_out2), .mm_out(mm_out2),
      .mm_reset(mm_reset2), .dbg_state(dbg_state2)
   );

   // Behavioural multipliers: write port, synchronous clear, C read.
   logic signed [7:0]  ma[4], mb[4], ma2[4], mb2[4];
   logic signed [16:0] c1[4], c2[4];
   logic [1:0]         a2_d1, a2_d2;

   function automatic logic signed [16:0] mac(input logic signed [7:0] a0, b0, a1, b1);
      return 17'(a0) * 17'(b0) + 17'(a1) * 17'(b1);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset || mm_reset) begin
         for (int i = 0; i < 4; i++) begin ma[i] <= 8'sd0; mb[i] <= 8'sd0; end
      end else if (mm_data_in) begin
         if (mm_mem_sel) mb[{mm_row_in, mm_col_in}] <= mm_data;
         else            ma[{mm_row_in, mm_col_in}] <= mm_data;
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset || mm_reset2) begin
         for (int i = 0; i < 4; i++) begin ma2[i] <= 8'sd0; mb2[i] <= 8'sd0; end
      end else if (mm_data_in2) begin
         if (mm_mem_sel2) mb2[{mm_row_in2, mm_col_in2}] <= mm_data2;
         else             ma2[{mm_row_in2, mm_col_in2}] <= mm_data2;
      end
   end

   always_comb begin
      c1[0] = mac(ma[0], mb[0], ma[1], mb[2]);
      c1[1] = mac(ma[0], mb[1], ma[1], mb[3]);
      c1[2] = mac(ma[2], mb[0], ma[3], mb[2]);
      c1[3] = mac(ma[2], mb[1], ma[3], mb[3]);
      c2[0] = mac(ma2[0], mb2[0], ma2[1], mb2[2]);
      c2[1] = mac(ma2[0], mb2[1], ma2[1], mb2[3]);
      c2[2] = mac(ma2[2], mb2[0], ma2[3], mb2[2]);
      c2[3] = mac(ma2[2], mb2[1], ma2[3], mb2[3]);
   end

   // Read latency 1: combinational. Read latency 3: two address stages.
   assign mm_out = c1[{mm_row_out, mm_col_out}];
   always @(posedge clk) begin
      a2_d1 <= {mm_row_out2, mm_col_out2};
      a2_d2 <= a2_d1;
   end
   assign mm_out2 = c2[a2_d2];

   // Scoreboard state
   logic [19:0] exp_q[$];
   logic [19:0] exp2_q[$];
   logic [10:0] wr_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int rst_cnt = 0;
   int wr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   // Monitors sample on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         if (m_valid && m_ready && !abort) begin
            if (exp_q.size() == 0) note_fail("out_unexpected");
            else check("out_last_idx_data", {12'd0, m_last, m_idx, m_data}, {12'd0, exp_q.pop_front()});
         end
         if (mm_data_in) begin
            wr_cnt++;
            if (wr_q.size() == 0) note_fail("write_unexpected");
            else check("write_sel_row_col_data", {21'd0, mm_mem_sel, mm_row_in, mm_col_in, mm_data},
                       {21'd0, wr_q.pop_front()});
         end
         if (done) done_cnt++;
         if (mm_reset) rst_cnt++;
         if (m_valid2 && m_ready2 && !abort2) begin
            if (exp2_q.size() == 0) note_fail("sweep_out_unexpected");
            else check("sweep_out_last_idx_data", {12'd0, m_last2, m_idx2, m_data2}, {12'd0, exp2_q.pop_front()});
         end
      end
   end

   // Drives one beat on instance 0 (sel=0) or the sweep instance (sel=1).
   task automatic send_beat(input bit sel, input int idx, input logic [7:0] d);
      logic acc;
      acc = 1'b0;
      if (sel) begin s_valid2 = 1'b1; s_data2 = d; end
      else     begin s_valid  = 1'b1; s_data  = d; end
      for (int b = 0; b < 50; b++) begin
         acc = sel ? (s_ready2 && !abort2) : (s_ready && !abort);
         @(posedge clk); #1;
         if (acc) break;
      end
      if (sel) s_valid2 = 1'b0;
      else     s_valid  = 1'b0;
      if (!acc) note_fail("beat_accept");
      else if (!sel) wr_q.push_back({idx[2:0], d});
   endtask

   task automatic run_job(input logic [63:0] beats, input logic [67:0] expv, input bit gap, input bit stall);
      int k;
      int d0, r0, w0;
      d0 = done_cnt; r0 = rst_cnt; w0 = wr_cnt;
      for (int i = 0; i < 4; i++)
         exp_q.push_back({(i == 3), 2'(i), expv[i*17 +: 17]});
      for (int i = 0; i < 8; i++) begin
         send_beat(1'b0, i, beats[i*8 +: 8]);
         if (gap && i < 7) begin @(posedge clk); #1; end
      end
      k = 0;
      while (!m_valid && k < 60) begin @(posedge clk); #1; k++; end
      check("first_valid_latency", k, 3);
      if (stall) begin
         @(posedge clk); #1;
         m_ready = 1'b0;
         k = 0;
         while (!m_valid && k < 20) begin @(posedge clk); #1; k++; end
         for (int j = 0; j < 5; j++) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, 22);
            check("stall_idx", m_idx, 1);
            check("stall_rd_addr", {mm_row_out, mm_col_out}, 2'b01);
            @(posedge clk); #1;
         end
         m_ready = 1'b1;
      end
      k = 0;
      while ((busy || exp_q.size() != 0) && k < 200) begin @(posedge clk); #1; k++; end
      if (k == 200) note_fail("job_complete");
      check("done_pulses", done_cnt - d0, 1);
      check("clear_cycles", rst_cnt - r0, 1);
      check("write_strobes", wr_cnt - w0, 8);
   endtask

   localparam logic [63:0] BASIC_BEATS = 64'h0807060504030201;
   localparam logic [67:0] BASIC_C     = {17'd50, 17'd43, 17'd22, 17'd19};

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $fatal(1, "global timeout");
   end

   initial begin
      int k;
      int d0, r0;
      logic [63:0] beats;
      reset = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
      abort2 = 1'b0; s_valid2 = 1'b0; s_data2 = 8'd0; m_ready2 = 1'b1;

      // Reset values
      @(posedge clk); #1;
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_mm_reset", mm_reset, 0);
      check("rst_mm_data_in", mm_data_in, 0);
      check("rst_state", dbg_state, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      check("rel_s_ready_before_clock", s_ready, 0);
      @(posedge clk); #1;
      check("rel_s_ready_first_clock", s_ready, 1);

      // Basic job, signed extremes
      run_job(BASIC_BEATS, BASIC_C, 1'b0, 1'b0);
      run_job(64'h8080808080808080, {4{17'h08000}}, 1'b0, 1'b0);
      run_job(64'h7F7F7F7F80808080, {4{17'h18100}}, 1'b0, 1'b0);

      // Input gaps with backpressure on C01
      run_job(BASIC_BEATS, BASIC_C, 1'b1, 1'b1);

      // Abort after five beats, then a clean job
      d0 = done_cnt; r0 = rst_cnt;
      for (int i = 0; i < 5; i++) send_beat(1'b0, i, BASIC_BEATS[i*8 +: 8]);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_mm_reset", mm_reset, 1);
      check("abort_done", done, 0);
      check("abort_s_ready", s_ready, 0);
      check("abort_state_clear", dbg_state, 4);
      @(posedge clk); #1;
      check("abort_s_ready_back", s_ready, 1);
      check("abort_busy_idle", busy, 0);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_clear_cycles", rst_cnt - r0, 1);
      run_job(BASIC_BEATS, BASIC_C, 1'b0, 1'b0);

      // Asynchronous reset while a result is presented
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_beat(1'b0, i, BASIC_BEATS[i*8 +: 8]);
      k = 0;
      while (!m_valid && k < 60) begin @(posedge clk); #1; k++; end
      check("send_valid_before_reset", m_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_m_valid", m_valid, 0);
      check("async_busy", busy, 0);
      check("async_mm_reset", mm_reset, 0);
      check("async_mm_data_in", mm_data_in, 0);
      check("async_state", dbg_state, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("async_rel_s_ready", s_ready, 1);
      check("async_rel_busy", busy, 0);

      // Latency sweep instance: settle 4, read latency 3
      beats = BASIC_BEATS;
      for (int i = 0; i < 4; i++)
         exp2_q.push_back({(i == 3), 2'(i), BASIC_C[i*17 +: 17]});
      for (int i = 0; i < 8; i++) send_beat(1'b1, i, beats[i*8 +: 8]);
      k = 0;
      while (!m_valid2 && k < 60) begin @(posedge clk); #1; k++; end
      check("sweep_first_valid_latency", k, 7);
      k = 0;
      while ((busy2 || exp2_q.size() != 0) && k < 200) begin @(posedge clk); #1; k++; end
      if (k == 200) note_fail("sweep_job_complete");

      check("exp_q_drained", exp_q.size(), 0);
      check("wr_q_drained", wr_q.size(), 0);
      check("exp2_q_drained", exp2_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
